// File: rtl/threshold_voter.sv
// Registered N-channel threshold voter with persistence-based channel fault isolation.
// Channels that disagree with the vote for PERSIST consecutive valid samples become sticky-faulted.
module threshold_voter #(
  parameter int unsigned N       = 3,
  parameter int unsigned THRESH  = 2,
  parameter int unsigned PERSIST = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in,
  input  logic [N-1:0] mask,
  input  logic         clr_fault,
  output logic         o,
  output logic         o_valid,
  output logic         agree,
  output logic         no_quorum,
  output logic [N-1:0] fault
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned PW = $clog2(PERSIST + 1);

  logic                  o_q, o_d;
  logic                  o_valid_q, o_valid_d;
  logic                  agree_q, agree_d;
  logic                  no_quorum_q, no_quorum_d;
  logic [N-1:0]          fault_q, fault_d;
  logic [N-1:0][PW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]  en;
  logic [CW-1:0] ones;
  logic [CW-1:0] nen;
  logic          vote;
  logic          nq;
  logic          all_match;

  // Vote datapath: enabled set uses the fault register as it stood before this edge.
  always_comb begin
    en   = ~mask & ~fault_q;
    ones = '0;
    nen  = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + CW'(in[i] & en[i]);
      nen  = nen + CW'(en[i]);
    end
    vote      = (ones >= CW'(THRESH));
    nq        = (nen < CW'(THRESH));
    all_match = (((in ^ {N{vote}}) & en) == '0);
  end

  always_comb begin
    o_d         = o_q;
    agree_d     = agree_q;
    no_quorum_d = no_quorum_q;
    o_valid_d   = in_valid;
    fault_d     = fault_q;
    cnt_d       = cnt_q;

    if (in_valid) begin
      o_d         = vote;
      no_quorum_d = nq;
      agree_d     = !nq && all_match;
      for (int i = 0; i < N; i++) begin
        if (en[i]) begin
          if (in[i] != vote) begin
            if (cnt_q[i] != PW'(PERSIST)) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
            if (cnt_d[i] == PW'(PERSIST)) begin
              fault_d[i] = 1'b1;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
      end
    end

    // Clear wins over any increment or fault set on the same edge.
    if (clr_fault) begin
      fault_d = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q         <= 1'b0;
      o_valid_q   <= 1'b0;
      agree_q     <= 1'b0;
      no_quorum_q <= 1'b0;
      fault_q     <= '0;
      cnt_q       <= '0;
    end else begin
      o_q         <= o_d;
      o_valid_q   <= o_valid_d;
      agree_q     <= agree_d;
      no_quorum_q <= no_quorum_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o         = o_q;
  assign o_valid   = o_valid_q;
  assign agree     = agree_q;
  assign no_quorum = no_quorum_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_threshold_voter.sv
// Directed self-checking bench for threshold_voter (N=3, THRESH=2, PERSIST=3).
// Observed vector is {o, o_valid, agree, no_quorum, fault[2:0]}.
module tb_threshold_voter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in;
  logic [2:0] mask;
  logic       clr_fault;
  logic       o;
  logic       o_valid;
  logic       agree;
  logic       no_quorum;
  logic [2:0] fault;

  int n_checks;
  int n_fail;
  logic [6:0] obs;

  threshold_voter #(
    .N      (3),
    .THRESH (2),
    .PERSIST(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in       (in),
    .mask     (mask),
    .clr_fault(clr_fault),
    .o        (o),
    .o_valid  (o_valid),
    .agree    (agree),
    .no_quorum(no_quorum),
    .fault    (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {o, o_valid, agree, no_quorum, fault};

  // Apply one cycle of stimulus, then settle 1 time unit past the edge.
  task automatic step(input logic v, input logic [2:0] d, input logic [2:0] m, input logic c);
    in_valid  = v;
    in        = d;
    mask      = m;
    clr_fault = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in        = '0;
    mask      = '0;
    clr_fault = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    // Power-on reset
    do_reset();
    n_checks++;
    if (obs !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL reset_initial: got %b want %b", obs, 7'b0000_000);
    end
    // Build fault=100, o=1 then reset mid-stream
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1100_100) begin
      n_fail++;
      $display("FAIL reset_setup: got %b want %b", obs, 7'b1100_100);
    end
    in_valid = 1'b1;
    in       = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL reset_async: got %b want %b", obs, 7'b0000_000);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    n_checks++;
    if (obs !== 7'b0000_000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs, 7'b0000_000);
    end
    step(1'b1, 3'b110, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1100_000) begin
      n_fail++;
      $display("FAIL reset_first_sample: got %b want %b", obs, 7'b1100_000);
    end
  endtask

  task automatic test_basic_vote();
    do_reset();
    step(1'b1, 3'b000, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b0110_000) begin
      n_fail++;
      $display("FAIL basic_000: got %b want %b", obs, 7'b0110_000);
    end
    step(1'b1, 3'b101, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1100_000) begin
      n_fail++;
      $display("FAIL basic_101: got %b want %b", obs, 7'b1100_000);
    end
    step(1'b1, 3'b111, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1110_000) begin
      n_fail++;
      $display("FAIL basic_111: got %b want %b", obs, 7'b1110_000);
    end
    // Gap: o/agree hold, o_valid drops
    step(1'b0, 3'b000, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1010_000) begin
      n_fail++;
      $display("FAIL basic_gap_hold: got %b want %b", obs, 7'b1010_000);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] pat [6];
    logic       exp_o [6];
    pat   = '{3'b000, 3'b111, 3'b001, 3'b110, 3'b010, 3'b011};
    exp_o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, pat[i], 3'b000, 1'b0);
      n_checks++;
      if (o !== exp_o[i] || o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_%0d: got o=%b ov=%b want o=%b ov=1", i, o, o_valid, exp_o[i]);
      end
    end
  endtask

  task automatic test_persistence();
    do_reset();
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1100_000) begin
      n_fail++;
      $display("FAIL persist_2nd: got %b want %b", obs, 7'b1100_000);
    end
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1100_100) begin
      n_fail++;
      $display("FAIL persist_3rd: got %b want %b", obs, 7'b1100_100);
    end
    step(1'b1, 3'b001, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b0100_100) begin
      n_fail++;
      $display("FAIL persist_excluded_001: got %b want %b", obs, 7'b0100_100);
    end
    // Faulted ch2 no longer spoils agreement
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1110_100) begin
      n_fail++;
      $display("FAIL persist_excluded_011: got %b want %b", obs, 7'b1110_100);
    end
    // mask does not clear fault
    step(1'b1, 3'b011, 3'b100, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1110_100) begin
      n_fail++;
      $display("FAIL persist_mask_sticky: got %b want %b", obs, 7'b1110_100);
    end
  endtask

  task automatic test_interrupted();
    logic [2:0] seq [5];
    seq = '{3'b011, 3'b011, 3'b111, 3'b011, 3'b011};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 3'b000, 1'b0);
    end
    n_checks++;
    if (fault !== 3'b000) begin
      n_fail++;
      $display("FAIL interrupted_no_fault: got %b want %b", fault, 3'b000);
    end
    step(1'b1, 3'b111, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b0, 3'b111, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b0, 3'b111, 3'b000, 1'b0);
    n_checks++;
    if (fault !== 3'b000) begin
      n_fail++;
      $display("FAIL gaps_before_3rd: got %b want %b", fault, 3'b000);
    end
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (fault !== 3'b100) begin
      n_fail++;
      $display("FAIL gaps_fault: got %b want %b", fault, 3'b100);
    end
  endtask

  task automatic test_quorum_loss();
    do_reset();
    step(1'b1, 3'b111, 3'b011, 1'b0);
    n_checks++;
    if (obs !== 7'b0101_000) begin
      n_fail++;
      $display("FAIL quorum_111: got %b want %b", obs, 7'b0101_000);
    end
    step(1'b1, 3'b000, 3'b011, 1'b0);
    n_checks++;
    if (obs !== 7'b0101_000) begin
      n_fail++;
      $display("FAIL quorum_000: got %b want %b", obs, 7'b0101_000);
    end
    // nen == THRESH is enough for quorum
    step(1'b1, 3'b110, 3'b001, 1'b0);
    n_checks++;
    if (obs !== 7'b1110_000) begin
      n_fail++;
      $display("FAIL quorum_boundary: got %b want %b", obs, 7'b1110_000);
    end
  endtask

  task automatic test_clr_fault();
    do_reset();
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b1);
    n_checks++;
    if (obs !== 7'b1100_000) begin
      n_fail++;
      $display("FAIL clr_priority: got %b want %b", obs, 7'b1100_000);
    end
    // Counters were zeroed: two more disagreements stay clean, third faults
    step(1'b1, 3'b011, 3'b000, 1'b0);
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (fault !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_cnt_zeroed: got %b want %b", fault, 3'b000);
    end
    step(1'b1, 3'b011, 3'b000, 1'b0);
    n_checks++;
    if (fault !== 3'b100) begin
      n_fail++;
      $display("FAIL clr_refault: got %b want %b", fault, 3'b100);
    end
    // Coincident sample votes with pre-clear fault (ch2 still excluded)
    step(1'b1, 3'b100, 3'b000, 1'b1);
    n_checks++;
    if (obs !== 7'b0110_000) begin
      n_fail++;
      $display("FAIL clr_preclear_vote: got %b want %b", obs, 7'b0110_000);
    end
    step(1'b1, 3'b101, 3'b000, 1'b0);
    n_checks++;
    if (obs !== 7'b1100_000) begin
      n_fail++;
      $display("FAIL clr_ch2_rejoins: got %b want %b", obs, 7'b1100_000);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in        = '0;
    mask      = '0;
    clr_fault = 1'b0;
    test_reset();
    test_basic_vote();
    test_back_to_back();
    test_persistence();
    test_interrupted();
    test_quorum_loss();
    test_clr_fault();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/threshold_voter.md
# threshold_voter

Registered N-channel threshold voter with persistence-based channel fault isolation. It is the sequential, parametrised successor to the team's 3-input combinational voting logic. Each valid sample is voted over the enabled channels and the result is registered. Each channel is tracked for consecutive disagreement with the vote, and a sticky fault excludes that channel from later votes. It sits between redundant sensor/decoder channels and downstream control logic.

## Interface
- N, default 3: channel count, N >= 2
- THRESH, default 2: minimum number of enabled '1' inputs for o = 1; 1 <= THRESH <= N
- PERSIST, default 3: consecutive disagreeing samples before a channel faults; PERSIST >= 1
- clk  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  sample qualifier
- in  input  N  one bit per channel
- mask  input  N  1 = channel permanently excluded by software (sampled with in_valid)
- clr_fault  input  1  synchronous pulse: clears all faults and disagreement counters
- o  output  1  registered vote
- o_valid  output  1  registered copy of in_valid
- agree  output  1  all enabled channels matched the vote (quorum met)
- no_quorum  output  1  enabled channel count < THRESH for this sample
- fault  output  N  sticky per-channel fault flags

## Operation
- Enabled set: en = ~mask & ~fault, using the fault register value before the current edge.
- Per valid sample:
  - ones = popcount(in & en), width clog2(N+1).
  - nen = popcount(en).
  - vote = (ones >= THRESH).
  - nq = (nen < THRESH).
- Registered on in_valid = 1:
  - o <= vote.
  - no_quorum <= nq.
  - agree <= !nq && all enabled in[i] == vote.
  - If nq, vote is necessarily 0 and o <= 0.
- Registered on in_valid = 0:
  - o, agree and no_quorum hold their values.
  - o_valid <= 0.
  - Disagreement counters are untouched; gaps neither advance nor reset persistence.
- Per-channel counter cnt[i], width clog2(PERSIST+1), saturating at PERSIST. Updated only on in_valid = 1, en[i] = 1, clr_fault = 0:
  - in[i] != vote: cnt[i] <= cnt[i] + 1. If the new value equals PERSIST, fault[i] <= 1 on the same edge.
  - in[i] == vote: cnt[i] <= 0.
- Masked or faulted channels: cnt[i] holds and never contributes to ones, nen or agree.
- Faults are sticky. Only rst or clr_fault clears them. mask does not clear fault.
- clr_fault = 1:
  - All fault and cnt bits go to 0 at the edge.
  - This takes priority over any increment or fault set on the same edge.
  - The vote for a coincident valid sample still uses the pre-clear fault value.
- rst asserted:
  - o = 0, o_valid = 0, agree = 0, no_quorum = 0, fault = 0, all cnt = 0, immediately and asynchronously.
  - A sample in flight is discarded; nothing is emitted after release.

## Timing
- Latency: a sample presented with in_valid at edge k appears on o/o_valid/agree/no_quorum after edge k. There is one cycle of latency and throughput is one sample per cycle.
- A fault raised at edge k excludes channel i from the vote of the sample at edge k+1 onward. The sample that triggers the fault is still voted with channel i included.
- First valid sample after rst release is accepted normally, with no warm-up cycle.
- All outputs are glitch-free registers; there is no combinational path from input to output.

## Test plan
- Reset: assert rst mid-stream with fault = 3'b100 and o = 1 -> all outputs 0 asynchronously; after release, in = 3'b110 valid -> next cycle o = 1, o_valid = 1, agree = 0.
- Basic vote (N = 3, THRESH = 2): in = 000 -> o = 0, agree = 1; in = 101 -> o = 1, agree = 0; in = 111 -> o = 1, agree = 1.
- Persistence: in = 011 for 3 consecutive valid cycles -> fault = 100 after the 3rd edge. Then in = 001 -> nen = 2, ones = 1, o = 0, no_quorum = 0.
- Interrupted disagreement: in = 011, 011, 111, 011, 011 -> fault stays 000. Gaps of in_valid = 0 between disagreeing samples do not reset the count: 011, gap, 011, gap, 011 -> fault = 100.
- Quorum loss: mask = 011 -> nen = 1 < 2 -> o = 0, no_quorum = 1, agree = 0 regardless of in.
- clr_fault priority: assert clr_fault on the edge of the 3rd disagreeing sample -> fault stays 000 and all cnt = 0. Assert clr_fault with fault = 100 -> fault = 000 next cycle, and channel 2 votes again from the following sample.
